// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// -----------------------------------------------------------------------------
// Pops words from the TX FIFO (show-ahead read port) and shifts each one out on
// txd as an asynchronous serial frame: start bit, data LSB first, optional
// parity bit, then one or two stop bits. The bit period is baud_div+1 clocks.
// Frame settings are captured when a word is popped, so changing them mid-frame
// only affects the next frame.
//
// Configuration macro: UART_TX_PARITY_EN
//   defined   - PARITY state compiled in; parity_en / parity_odd are honoured.
//   undefined - no parity bit; parity_en / parity_odd are ignored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tx_en        allow popping new words (a frame in flight always completes)
//   baud_div     bit period minus one, in clk cycles
//   stop2        1: two stop bits, 0: one stop bit
//   parity_en    add a parity bit (UART_TX_PARITY_EN builds only)
//   parity_odd   1: odd parity, 0: even parity
//   fifo_empty   FIFO empty flag
//   fifo_dout    FIFO head word, valid while fifo_empty=0
//   fifo_rd      pop strobe, one cycle per word
//   txd          registered serial output, idles high
//   busy         high whenever a frame is in progress
//   tx_done      one-cycle pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  stop2,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic                  txd,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DIV_WIDTH-1:0]   baud_q,  baud_d;
    logic [DIV_WIDTH-1:0]   div_q,   div_d;
    logic [BIT_CNT_W-1:0]   bit_q,   bit_d;
    logic                   stop_q,  stop_d;     // second stop bit in progress
    logic                   stop2_q, stop2_d;
    logic                   txd_q,   txd_d;

`ifdef UART_TX_PARITY_EN
    logic                   par_en_q,  par_en_d;
    logic                   par_bit_q, par_bit_d;
`else
    logic                   unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    logic launch;
    logic do_launch;
    logic bit_end;

    // Gated by rst_n so no word is popped (and lost) while the block is held
    // in reset.
    assign launch  = rst_n & tx_en & ~fifo_empty;
    assign bit_end = (baud_q == '0);

    // NOTE: every variable gets a default before the case statement; without
    // it, paths that do not assign a signal would infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        baud_d    = baud_q;
        div_d     = div_q;
        bit_d     = bit_q;
        stop_d    = stop_q;
        stop2_d   = stop2_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        do_launch = 1'b0;
        fifo_rd   = 1'b0;
        tx_done   = 1'b0;

        case (state_q)
            S_IDLE: do_launch = launch;

            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = div_q;
                    bit_d   = '0;
                end else begin
                    baud_d  = baud_q - 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    baud_d  = div_q;
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d  = '0;
                        stop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = div_q;
                    stop_d  = 1'b0;
                end else begin
                    baud_d  = baud_q - 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                        baud_d = div_q;
                    end else begin
                        // Last cycle of the frame: relaunch with no idle gap
                        // if another word is ready.
                        tx_done = 1'b1;
                        stop_d  = 1'b0;
                        if (launch) begin
                            do_launch = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            baud_d  = '0;
                        end
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        if (do_launch) begin
            fifo_rd   = 1'b1;
            state_d   = S_START;
            shift_d   = fifo_dout;
            div_d     = baud_div;
            baud_d    = baud_div;
            stop2_d   = stop2;
            bit_d     = '0;
            stop_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_d  = parity_en;
            par_bit_d = (^fifo_dout) ^ parity_odd;
`endif
        end

        // txd is registered, so it is computed from the state being entered.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_bit_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: the shift register is reset too; it is only a few flops and keeps
    // txd and the state fully defined straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            baud_q    <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            stop_q    <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            baud_q    <= baud_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            stop_q    <= stop_d;
            stop2_q   <= stop2_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    assign txd  = txd_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit serializer for the simple UART, sitting directly downstream of the TX synchronous FIFO. It pops one word at a time from the FIFO head using the FIFO's show-ahead read port, and shifts each word out on `txd` as an asynchronous serial frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from a programmable clock divider. The block is fully synchronous to `clk`.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame; must match the FIFO width.
- `DIV_WIDTH`, default 16: width of the baud divisor.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tx_en` in 1: enables popping new words; a frame in flight always completes.
- `baud_div` in DIV_WIDTH: bit period is `baud_div`+1 clk cycles.
- `stop2` in 1: 1 selects two stop bits, 0 selects one.
- `parity_en` in 1: adds a parity bit (active only with `UART_TX_PARITY_EN`).
- `parity_odd` in 1: 1 selects odd parity, 0 selects even.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in DATA_WIDTH: FIFO head word, valid combinationally while `fifo_empty`=0.
- `fifo_rd` out 1: pop strobe, one cycle per word.
- `txd` out 1: serial line, registered, idles high.
- `busy` out 1: high whenever the state is not IDLE.
- `tx_done` out 1: one-cycle pulse on the last cycle of the final stop bit.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- **Launch condition** `launch = tx_en & ~fifo_empty`, evaluated in IDLE or on the last cycle of STOP. On launch, in the same cycle:
  - `fifo_rd`=1;
  - `fifo_dout` is latched into the shift register;
  - `baud_div`, `stop2`, `parity_en` and `parity_odd` are latched for the whole frame;
  - next state is START.
- START: `txd`=0 for one bit period, then go to DATA.
- DATA: `txd`=shift[0]. Shift right once per bit period. A bit counter counts 0..DATA_WIDTH-1; after the last bit go to PARITY if parity is latched enabled, else STOP.
- PARITY: `txd` = XOR of the latched data, inverted when `parity_odd`=1.
- STOP: `txd`=1 for 1 or 2 bit periods. On the last cycle, `tx_done`=1 and the launch condition is re-evaluated. If it is true, the next state is START with no idle gap; if false, the next state is IDLE.
- Baud counter: loads the latched divisor at each bit start and decrements to 0. A bit ends on the cycle the counter reads 0. `baud_div`=0 gives a 1-cycle bit.
- `fifo_rd` is never asserted while `fifo_empty`=1, so the FIFO never underflows.
- Changes to `baud_div`, `stop2` or the parity inputs during a frame have no effect until the next launch.
- Deasserting `tx_en` mid-frame finishes the current frame, then the block enters IDLE.

## Timing
- Reset values: `txd`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, state IDLE, counters 0.
- Reset mid-frame: `txd` returns to 1 immediately (asynchronous). The popped word is lost; the FIFO is not rewound.
- Launch to line: `fifo_rd` is high in cycle N; `txd` falls at the clock edge ending cycle N and is low from cycle N+1.
- Frame length: (1 + DATA_WIDTH + P + S) × (`baud_div`+1) cycles, where P is 0 or 1 (parity bit) and S is 1 or 2 (stop bits).
- Back-to-back frames: the start bit of the next frame directly follows the last stop cycle. There is no extra idle cycle.
- `busy` rises in cycle N+1 and falls the cycle after the final `tx_done` when no relaunch occurs.
- Latency from `fifo_empty` falling to `fifo_rd` is 0 cycles when in IDLE with `tx_en`=1.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and `parity_en`/`parity_odd` behave as described above.
- `UART_TX_PARITY_EN` undefined: the PARITY state is removed, `parity_en`/`parity_odd` are ignored, and frames are always 1 + DATA_WIDTH + S bits.

## Test plan
- **Single frame:** FIFO holds 0x55, `baud_div`=3, `stop2`=0, parity off. Required: exactly one `fifo_rd` pulse, then `txd` = 0,1,0,1,0,1,0,1,0,1 with each bit lasting 4 cycles, a 40-cycle frame, and `tx_done` on cycle 40.
- **Back-to-back frames:** FIFO holds 0xA5 then 0x3C, `baud_div`=0. Required: second `fifo_rd` on the same cycle as the first `tx_done`, the 0x3C start bit on the next cycle, two frames totalling 20 cycles, and `busy` high throughout.
- **Empty FIFO:** FIFO empty with `tx_en`=1 for 100 cycles. Required: `fifo_rd`=0, `txd`=1 and `busy`=0 throughout. Then set `tx_en`=0 while a word is pending: no pop occurs.
- **Parity, stop bits, divisor change** (macro defined): 0x07, `parity_en`=1, `parity_odd`=1, `stop2`=1, `baud_div`=1. Required: parity bit 0, two stop bits, a 24-cycle frame. Changing `baud_div` to 9 mid-frame does not alter that frame.
- **Reset mid-frame:** assert `rst_n` low during the DATA state of 0xFF. Required: `txd`=1, `busy`=0 and `fifo_rd`=0 immediately. After release, the next FIFO word is sent as a clean full frame.
